// File: rtl/mxn_elastic_pipeline.sv
// M-bit, N-stage valid/ready pipeline with bubble collapse, synchronous flush and occupancy count.
// The ready chain runs combinationally from out_ready back to in_ready.
module mxn_elastic_pipeline #(
    parameter  int unsigned M  = 3,
    parameter  int unsigned N  = 4,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  out_data,
    output logic [CW-1:0] count
);

    logic [M-1:0]  data_q [N];
    logic [M-1:0]  data_d [N];
    logic [N-1:0]  vld_q;
    logic [N-1:0]  vld_d;
    logic [N-1:0]  adv;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          in_fire;
    logic          out_fire;

    // A stage advances if it is empty or everything downstream of it advances.
    always_comb begin : p_adv
        logic chain;
        chain    = !vld_q[N-1] || out_ready;
        adv      = '0;
        adv[N-1] = chain;
        for (int i = int'(N) - 2; i >= 0; i--) begin
            chain  = !vld_q[i] || chain;
            adv[i] = chain;
        end
    end

    assign in_ready  = adv[0] && !flush && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = vld_q[N-1] && out_ready;
    assign out_valid = vld_q[N-1];
    assign out_data  = data_q[N-1];
    assign count     = count_q;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (adv[0]) begin
            data_d[0] = in_data;
            vld_d[0]  = in_fire;
        end
        for (int i = 1; i < int'(N); i++) begin
            if (adv[i]) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
        end
        count_d = count_q + CW'(in_fire) - CW'(out_fire);
        // Flush drops valids only; the head word may still transfer this cycle.
        if (flush) begin
            vld_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_mxn_elastic_pipeline.sv
// Bench for mxn_elastic_pipeline: directed vector table on M=3/N=4 plus randomized traffic on
// three configurations checked against a queue-based timing model.
module tb_mxn_elastic_pipeline;

    localparam int NI = 3;

    typedef struct {
        logic [15:0] d;
        int          avail;
    } ent_t;

    typedef struct {
        bit          r, f, iv;
        logic [2:0]  d;
        bit          ordy;
        bit          e_ir, e_ov;
        logic [2:0]  e_od;
        bit          c_od;
        int          e_cnt;
        bit          c_st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst       [NI];
    logic        flush     [NI];
    logic        in_valid  [NI];
    logic        out_ready [NI];
    logic [15:0] in_data   [NI];
    logic        in_ready  [NI];
    logic        out_valid [NI];
    logic [15:0] out_data  [NI];
    logic [7:0]  count     [NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned PM  = (g == 0) ? 3 : (g == 1) ? 8 : 16;
        localparam int unsigned PN  = (g == 0) ? 4 : (g == 1) ? 1 : 8;
        localparam int unsigned PCW = $clog2(PN + 1);

        logic [PM-1:0]  od;
        logic [PCW-1:0] cnt;

        mxn_elastic_pipeline #(.M(PM), .N(PN)) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .flush    (flush[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g][PM-1:0]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (od),
            .count    (cnt)
        );

        assign out_data[g] = 16'(od);
        assign count[g]    = 8'(cnt);

        // Model: FIFO of accepted words; each becomes visible N-1 edges after acceptance,
        // but never before the word ahead of it has left.
        ent_t mq[$];
        int   cyc   = 0;
        bit   armed = 0;

        always @(negedge clk) begin : p_chk
            bit eov, eir;
            if (armed) begin
                eov = mq.size() > 0 && cyc >= mq[0].avail;
                eir = !rst[g] && !flush[g] && (mq.size() < int'(PN) || out_ready[g]);
                check("mdl_in_ready", g, 64'(in_ready[g]), 64'(eir));
                check("mdl_out_valid", g, 64'(out_valid[g]), 64'(eov));
                check("mdl_count", g, 64'(count[g]), 64'(mq.size()));
                if (eov) check("mdl_out_data", g, 64'(out_data[g]), 64'(mq[0].d));
            end
        end

        always @(posedge clk) begin : p_mdl
            bit eov, eir, ofire, ifire;
            eov = mq.size() > 0 && cyc >= mq[0].avail;
            eir = !rst[g] && !flush[g] && (mq.size() < int'(PN) || out_ready[g]);
            cyc++;
            if (rst[g]) begin
                mq.delete();
                armed = 1;
            end else if (armed) begin
                ofire = eov && out_ready[g];
                ifire = eir && in_valid[g];
                if (ofire) begin
                    void'(mq.pop_front());
                    if (mq.size() > 0 && mq[0].avail < cyc) mq[0].avail = cyc;
                end
                if (ifire) mq.push_back('{d: 16'(in_data[g][PM-1:0]), avail: cyc + int'(PN) - 1});
                if (flush[g]) mq.delete();
            end
        end
    end

    function automatic vec_t mk(bit r, bit f, bit iv, int d, bit o, bit eir, bit eov, int eod,
                                bit cod, int ecnt, bit cst);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = 3'(d); v.ordy = o;
        v.e_ir = eir; v.e_ov = eov; v.e_od = 3'(eod); v.c_od = cod; v.e_cnt = ecnt; v.c_st = cst;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b1; flush[g] = 1'b0; in_valid[g] = 1'b0; out_ready[g] = 1'b0;
            in_data[g] = '0;
        end

        //            r f iv d o  ir ov od cod cnt cst
        // reset
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,1,0,1));
        // streaming 1..7 at full rate
        tbl.push_back(mk(0,0,1,1,1, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,2,1, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,3,1, 1,0,0,0,2,1));
        tbl.push_back(mk(0,0,1,4,1, 1,0,0,0,3,1));
        tbl.push_back(mk(0,0,1,5,1, 1,1,1,1,4,1));
        tbl.push_back(mk(0,0,1,6,1, 1,1,2,1,4,1));
        tbl.push_back(mk(0,0,1,7,1, 1,1,3,1,4,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,4,1,4,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,5,1,3,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,6,1,2,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,7,1,1,1));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,1));
        // full stall, then release with a word waiting
        tbl.push_back(mk(0,0,1,5,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,6,0, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,7,0, 1,0,0,0,2,1));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,0,3,1));
        tbl.push_back(mk(0,0,1,3,0, 0,1,5,1,4,1));
        tbl.push_back(mk(0,0,1,3,1, 1,1,5,1,4,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,6,1,4,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,7,1,3,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,0,1,2,1));
        tbl.push_back(mk(0,0,0,0,1, 1,1,3,1,1,1));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,1));
        // bubble collapse under stall
        tbl.push_back(mk(0,0,1,2,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,4,0, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,1,2,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,1,2,1));
        tbl.push_back(mk(0,0,0,0,0, 1,1,2,1,2,1));
        // flush with head transfer, offered word refused
        tbl.push_back(mk(0,0,1,6,0, 1,1,2,1,2,1));
        tbl.push_back(mk(0,1,1,5,1, 0,1,2,1,3,1));
        tbl.push_back(mk(0,0,0,0,1, 1,0,0,0,0,1));
        // reset while full and stalled
        tbl.push_back(mk(0,0,1,1,0, 1,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,2,0, 1,0,0,0,1,1));
        tbl.push_back(mk(0,0,1,3,0, 1,0,0,0,2,1));
        tbl.push_back(mk(0,0,1,4,0, 1,0,0,0,3,1));
        tbl.push_back(mk(0,0,1,5,0, 0,1,1,1,4,1));
        tbl.push_back(mk(1,0,1,5,0, 0,1,1,1,4,1));
        tbl.push_back(mk(0,0,0,0,0, 1,0,0,1,0,1));

        foreach (tbl[k]) begin
            rst[0] = tbl[k].r; flush[0] = tbl[k].f; in_valid[0] = tbl[k].iv;
            in_data[0] = 16'(tbl[k].d); out_ready[0] = tbl[k].ordy;
            @(negedge clk);
            check("dir_in_ready", 0, 64'(in_ready[0]), 64'(tbl[k].e_ir));
            if (tbl[k].c_st) begin
                check("dir_out_valid", 0, 64'(out_valid[0]), 64'(tbl[k].e_ov));
                check("dir_count", 0, 64'(count[0]), 64'(tbl[k].e_cnt));
            end
            if (tbl[k].c_od) check("dir_out_data", 0, 64'(out_data[0]), 64'(tbl[k].e_od));
            @(posedge clk);
            #1;
        end

        // Streaming, then full stall, then mixed random traffic on every configuration.
        for (int p = 0; p < 1500; p++) begin
            for (int g = 0; g < NI; g++) begin
                rst[g]       = (p >= 120) && ($urandom_range(0, 299) == 0);
                flush[g]     = (p >= 120) && ($urandom_range(0, 39) == 0);
                in_valid[g]  = (p < 120) ? 1'b1 : ($urandom_range(0, 3) != 0);
                out_ready[g] = (p < 60) ? 1'b1 : (p < 120) ? 1'b0 :
                               ($urandom_range(0, 9) < (((p / 100) % 2 == 1) ? 3 : 8));
                in_data[g]   = 16'($urandom);
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
